instr_queue: RTL
================

// Module: instr_queue
// PURPOSE
// - In-order instruction queue between decode and the ROB / reservation stations.
// - Buffers decoded instructions in a circular FIFO.
// - Issues the head instruction when the ROB has room and the reservation station for its class is free.
// - Drives the ROB allocation interface (rob_load, instr_type, rd, st_src) and one-hot RS load strobes.
// - On branch_mispredict, drops every queued instruction.
// PARAMETERS
// - DEPTH  8  number of queue entries; power of two, >= 2
// PORTS
// - clk               in   1   clock, all state updates on posedge
// - rst               in   1   asynchronous reset, active-low (0 = in reset)
// - push              in   1   decode presents a valid instruction this cycle
// - push_type         in   op_t  tomasula_types op class (ALU, LD, ST, BRANCH)
// - push_rd           in   5   destination register
// - push_rs1          in   5   source register 1
// - push_rs2          in   5   source register 2 (store data source for ST)
// - push_imm          in   32  immediate
// - push_pc           in   32  instruction PC
// - iq_ready          out  1   queue can accept a push (= !full)
// - rob_full          in   1   ROB has no free entry
// - alu_rs_avail      in   1   ALU reservation station has a free slot
// - ldst_rs_avail     in   1   load/store station has a free slot
// - br_rs_avail       in   1   branch station has a free slot
// - branch_mispredict in   1   flush request from commit
// - rob_load          out  1   head issued this cycle (ROB allocate strobe)
// - instr_type        out  op_t  head op class
// - rd                out  5   head destination register
// - st_src            out  5   head rs2 when instr_type==ST, else 0
// - issue_rs1/rs2     out  5   head sources, to regfile/RS
// - issue_imm         out  32  head immediate
// - issue_pc          out  32  head PC
// - rs_load_alu/ldst/br  out  1 each  one-hot RS load strobe, equal to rob_load gated by class
// - iq_count          out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
// - Storage: DEPTH entries {type, rd, rs1, rs2, imm, pc}.
//   - head_ptr and tail_ptr are $clog2(DEPTH) bits wide; they wrap modulo DEPTH.
//   - count is tracked separately; full = (count==DEPTH), empty = (count==0).
// - Reset (rst==0, async):
//   - head_ptr=tail_ptr=count=0.
//   - All outputs 0: rob_load, rs_load_*, instr_type, rd, st_src, issue_* all 0; iq_ready=1.
//   - Entry payloads need not be cleared.
//   - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
// - Issue outputs are show-ahead and combinational from the head entry.
//   - When empty, they are 0.
//   - rob_load = !empty & !rob_full & !branch_mispredict & class_avail, where:
//     - ALU -> alu_rs_avail
//     - LD/ST -> ldst_rs_avail
//     - BRANCH -> br_rs_avail
//   - Exactly one rs_load_* is high iff rob_load is high.
// - Pop: on posedge with rob_load=1, head_ptr++ and count--. Issue is strictly in order; a blocked head blocks all entries behind it.
// - Push: accepted on posedge iff push & !full & !branch_mispredict.
//   - Write the entry at tail_ptr, then tail_ptr++ and count++.
//   - A push while full is dropped; decode must hold push until iq_ready.
// - Push+pop same cycle: both happen, count unchanged.
//   - At full, the push is still refused: iq_ready depends only on the registered count.
//   - At empty, there is no bypass: the pushed entry is visible at the head the next cycle.
// - Flush: branch_mispredict=1 at posedge sets head_ptr=tail_ptr=count=0.
//   - No issue occurs that cycle (rob_load forced 0).
//   - Any push in that cycle is dropped.
//   - Flush has priority over push and pop.
// - Latency: push at cycle N -> earliest rob_load in cycle N+1.
// - Throughput: 1 issue/cycle.
// - Wrap-around: pointers roll DEPTH-1 -> 0 with no bubble.
// - iq_count always equals the number of valid entries; it never exceeds DEPTH.
// TESTING
// - Reset, then 3 pushes (ALU rd=1, LD rd=2, ST rs2=7) with rob_full=0 and all avail=1:
//   - rob_load is high for 3 consecutive cycles, starting 1 cycle after the first push.
//   - Issues appear in order; st_src=7 on the ST only.
//   - rs_load_alu, then rs_load_ldst twice.
// - Fill 8 entries with rob_full=1:
//   - iq_ready=0 and iq_count=8.
//   - A 9th push is dropped.
//   - Release rob_full: 8 issues, in order, on consecutive cycles.
// - Head=BRANCH with br_rs_avail=0 and the next entry ALU with alu_rs_avail=1:
//   - No issue at all (in-order block).
//   - Raising br_rs_avail issues the BRANCH, then the ALU next cycle.
// - 5 entries queued; assert branch_mispredict together with a push:
//   - rob_load=0 that cycle.
//   - Next cycle iq_count=0, outputs are 0, and the pushed instruction is absent.
// - Run 20 push/pop pairs with push+pop every cycle:
//   - Pointers wrap twice.
//   - iq_count stays at 1; issued PCs match the pushed PCs in order.
// - Drive rst=0 asynchronously between clock edges with 4 entries queued:
//   - All outputs go to 0 immediately, iq_count=0, iq_ready=1.
//   - After release, the first push issues normally.

Source files
------------

// File: rtl/instr_queue.sv
// In-order instruction queue between decode and the ROB / reservation stations.
// Circular FIFO with show-ahead issue outputs taken directly from the head entry.

package tomasula_types;
  typedef enum logic [1:0] {
    ALU    = 2'd0,
    LD     = 2'd1,
    ST     = 2'd2,
    BRANCH = 2'd3
  } op_t;
endpackage

module instr_queue
  import tomasula_types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  op_t                        push_type,
  input  logic [4:0]                 push_rd,
  input  logic [4:0]                 push_rs1,
  input  logic [4:0]                 push_rs2,
  input  logic [31:0]                push_imm,
  input  logic [31:0]                push_pc,
  output logic                       iq_ready,
  input  logic                       rob_full,
  input  logic                       alu_rs_avail,
  input  logic                       ldst_rs_avail,
  input  logic                       br_rs_avail,
  input  logic                       branch_mispredict,
  output logic                       rob_load,
  output op_t                        instr_type,
  output logic [4:0]                 rd,
  output logic [4:0]                 st_src,
  output logic [4:0]                 issue_rs1,
  output logic [4:0]                 issue_rs2,
  output logic [31:0]                issue_imm,
  output logic [31:0]                issue_pc,
  output logic                       rs_load_alu,
  output logic                       rs_load_ldst,
  output logic                       rs_load_br,
  output logic [$clog2(DEPTH):0]     iq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    op_t         typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
  } iq_entry_t;

  iq_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              empty, full, push_ok, class_avail;
  iq_entry_t         head_e;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push_ok  = push & ~full & ~branch_mispredict;
  assign head_e   = mem_q[head_q];
  assign iq_ready = ~full;
  assign iq_count = count_q;

  // Show-ahead issue outputs; everything reads 0 while the queue is empty.
  always_comb begin
    rob_load     = 1'b0;
    instr_type   = ALU;
    rd           = '0;
    st_src       = '0;
    issue_rs1    = '0;
    issue_rs2    = '0;
    issue_imm    = '0;
    issue_pc     = '0;
    rs_load_alu  = 1'b0;
    rs_load_ldst = 1'b0;
    rs_load_br   = 1'b0;
    class_avail  = 1'b0;
    if (!empty) begin
      instr_type = head_e.typ;
      rd         = head_e.rd;
      st_src     = (head_e.typ == ST) ? head_e.rs2 : 5'd0;
      issue_rs1  = head_e.rs1;
      issue_rs2  = head_e.rs2;
      issue_imm  = head_e.imm;
      issue_pc   = head_e.pc;
      case (head_e.typ)
        ALU:     class_avail = alu_rs_avail;
        LD, ST:  class_avail = ldst_rs_avail;
        default: class_avail = br_rs_avail;
      endcase
      rob_load     = ~rob_full & ~branch_mispredict & class_avail;
      rs_load_alu  = rob_load & (head_e.typ == ALU);
      rs_load_ldst = rob_load & ((head_e.typ == LD) | (head_e.typ == ST));
      rs_load_br   = rob_load & (head_e.typ == BRANCH);
    end
  end

  // Pointer/count next state; a flush wins over any push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (branch_mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok)  tail_d = tail_q + 1'b1;
      if (rob_load) head_d = head_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(rob_load);
    end
  end

  // Control state; async reset empties the queue at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[tail_q] <= '{typ: push_type, rd: push_rd, rs1: push_rs1,
                         rs2: push_rs2, imm: push_imm, pc: push_pc};
    end
  end

endmodule
